// File: rtl/eeg_wram_arb_pkg.sv
// ============================================================================
// eeg_wram_arb_pkg : shared types and helpers for the WRAM port arbiter
// Revision: 1.0
// ============================================================================
`default_nettype none

package eeg_wram_arb_pkg;

  localparam int RBUF_DEPTH = 2;
  localparam int RR_MAXW    = 16;
  localparam int RR_IW      = 4;

  typedef enum logic [1:0] {
    GNT_IDLE = 2'd0,
    GNT_WR   = 2'd1,
    GNT_RD   = 2'd2
  } gnt_e;

  // One-hot winner of a round-robin search over vec[n-1:0] starting at ptr
  function automatic logic [RR_MAXW-1:0] rr_pick(input logic [RR_MAXW-1:0] vec,
                                                 input int unsigned       ptr,
                                                 input int unsigned       n);
    logic [RR_MAXW-1:0] oh;
    logic               found;
    int unsigned        idx;
    oh    = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < RR_MAXW; k++) begin
      idx = ptr + k;
      if (idx >= n) idx = idx - n;
      if (k < n && !found && vec[idx[RR_IW-1:0]]) begin
        oh[idx[RR_IW-1:0]] = 1'b1;
        found              = 1'b1;
      end
    end
    return oh;
  endfunction

endpackage

`default_nettype wire

// File: rtl/eeg_wram_ret_buf.sv
// ============================================================================
// eeg_wram_ret_buf : per-lane 2-entry read-return FIFO with occupancy count
// Revision: 1.0
// ============================================================================
`default_nettype none

module eeg_wram_ret_buf
  import eeg_wram_arb_pkg::*;
#(
  parameter int DAT_DW = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_push,
  input  logic [DAT_DW-1:0] i_din,
  output logic              o_vld,
  input  logic              i_rdy,
  output logic [DAT_DW-1:0] o_dat,
  output logic [1:0]        o_occ
);

  logic [DAT_DW-1:0] r_mem [RBUF_DEPTH];
  logic              r_wptr;
  logic              r_rptr;
  logic [1:0]        r_occ;
  logic              w_pop;

  assign o_vld = (r_occ != 2'd0);
  assign w_pop = o_vld && i_rdy;
  assign o_dat = r_mem[r_rptr];
  assign o_occ = r_occ;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wptr   <= 1'b0;
      r_rptr   <= 1'b0;
      r_occ    <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wptr] <= i_din;
        r_wptr        <= ~r_wptr;
      end
      if (w_pop) r_rptr <= ~r_rptr;
      case ({i_push, w_pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  // The arbiter's credit check must make a push into a full buffer impossible
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(i_push && !w_pop && r_occ == 2'(RBUF_DEPTH)));

endmodule

`default_nettype wire

// File: rtl/eeg_wram_arb.sv
// ============================================================================
// eeg_wram_arb : single-port WRAM arbiter, one writer vs REQ_NUM RR readers
// Revision: 1.0
// ============================================================================
`default_nettype none

module eeg_wram_arb
  import eeg_wram_arb_pkg::*;
#(
  parameter int REQ_NUM = 4,
  parameter int ADD_AW  = 9,
  parameter int DAT_DW  = 32,
  parameter int WR_MAX  = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ETOW_DAT_VLD,
  output logic                      ETOW_DAT_RDY,
  input  logic [ADD_AW-1:0]         ETOW_DAT_ADD,
  input  logic [DAT_DW-1:0]         ETOW_DAT_DAT,
  input  logic [REQ_NUM-1:0]        PTOW_ADD_VLD,
  output logic [REQ_NUM-1:0]        PTOW_ADD_RDY,
  input  logic [REQ_NUM*ADD_AW-1:0] PTOW_ADD_ADD,
  output logic [REQ_NUM-1:0]        PTOW_DAT_VLD,
  input  logic [REQ_NUM-1:0]        PTOW_DAT_RDY,
  output logic [REQ_NUM*DAT_DW-1:0] PTOW_DAT_DAT,
  output logic                      RAM_CEN,
  output logic                      RAM_WEN,
  output logic [ADD_AW-1:0]         RAM_ADD,
  output logic [DAT_DW-1:0]         RAM_DIN,
  input  logic [DAT_DW-1:0]         RAM_DOUT
);

  localparam int PW = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;
  localparam int SW = $clog2(WR_MAX + 1);

  logic [PW-1:0]      r_rr_ptr;
  logic [PW-1:0]      w_rr_nxt;
  logic [SW-1:0]      r_streak;
  logic [REQ_NUM-1:0] r_infl;
  logic [REQ_NUM-1:0] w_elig;
  logic [REQ_NUM-1:0] w_rd_oh;
  logic [1:0]         w_occ [REQ_NUM];
  logic [ADD_AW-1:0]  w_rd_add;
  logic [ADD_AW-1:0]  r_add_hold;
  logic [DAT_DW-1:0]  r_din_hold;
  logic               w_rd_any;
  gnt_e               w_gnt;

  generate
    for (genvar i = 0; i < REQ_NUM; i++) begin : g_lane
      // Credit: buffered entries plus the one still in the SRAM pipe
      assign w_elig[i] = PTOW_ADD_VLD[i] &&
                         (({1'b0, w_occ[i]} + {2'b00, r_infl[i]}) < 3'(RBUF_DEPTH));

      eeg_wram_ret_buf #(.DAT_DW(DAT_DW)) u_ret_buf (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_push (r_infl[i]),
        .i_din  (RAM_DOUT),
        .o_vld  (PTOW_DAT_VLD[i]),
        .i_rdy  (PTOW_DAT_RDY[i]),
        .o_dat  (PTOW_DAT_DAT[i*DAT_DW +: DAT_DW]),
        .o_occ  (w_occ[i])
      );
    end
  endgenerate

  always_comb begin
    w_rd_any = |w_elig;
    w_rd_oh  = REQ_NUM'(rr_pick(RR_MAXW'(w_elig), 32'(r_rr_ptr), REQ_NUM));
    w_rd_add = '0;
    w_rr_nxt = r_rr_ptr;
    for (int i = 0; i < REQ_NUM; i++) begin
      if (w_rd_oh[i]) begin
        w_rd_add = PTOW_ADD_ADD[i*ADD_AW +: ADD_AW];
        w_rr_nxt = (i == REQ_NUM - 1) ? '0 : PW'(i + 1);
      end
    end
    w_gnt = GNT_IDLE;
    if (ETOW_DAT_VLD && !(w_rd_any && r_streak == SW'(WR_MAX))) w_gnt = GNT_WR;
    else if (w_rd_any)                                         w_gnt = GNT_RD;
  end

  always_comb begin
    ETOW_DAT_RDY = (w_gnt == GNT_WR);
    PTOW_ADD_RDY = (w_gnt == GNT_RD) ? w_rd_oh : '0;
    RAM_CEN      = (w_gnt != GNT_IDLE);
    RAM_WEN      = (w_gnt == GNT_WR);
    // Address/data pins hold their last value on idle cycles to avoid toggling
    case (w_gnt)
      GNT_WR:  RAM_ADD = ETOW_DAT_ADD;
      GNT_RD:  RAM_ADD = w_rd_add;
      default: RAM_ADD = r_add_hold;
    endcase
    RAM_DIN = (w_gnt == GNT_WR) ? ETOW_DAT_DAT : r_din_hold;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr   <= '0;
      r_streak   <= '0;
      r_infl     <= '0;
      r_add_hold <= '0;
      r_din_hold <= '0;
    end else begin
      r_infl     <= PTOW_ADD_RDY;
      r_add_hold <= RAM_ADD;
      r_din_hold <= RAM_DIN;
      if (w_gnt == GNT_RD) r_rr_ptr <= w_rr_nxt;
      if (w_gnt == GNT_WR && w_rd_any) begin
        if (r_streak != SW'(WR_MAX)) r_streak <= r_streak + SW'(1);
      end else begin
        r_streak <= '0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_eeg_wram_arb.sv
// ============================================================================
// tb_eeg_wram_arb : vector table + scoreboard bench for eeg_wram_arb
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_eeg_wram_arb;
  localparam int RN = 4;
  localparam int AW = 9;
  localparam int DW = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              ETOW_DAT_VLD = 1'b0;
  logic              ETOW_DAT_RDY;
  logic [AW-1:0]     ETOW_DAT_ADD = '0;
  logic [DW-1:0]     ETOW_DAT_DAT = '0;
  logic [RN-1:0]     PTOW_ADD_VLD = '0;
  logic [RN-1:0]     PTOW_ADD_RDY;
  logic [RN*AW-1:0]  PTOW_ADD_ADD = '0;
  logic [RN-1:0]     PTOW_DAT_VLD;
  logic [RN-1:0]     PTOW_DAT_RDY = '1;
  logic [RN*DW-1:0]  PTOW_DAT_DAT;
  logic              RAM_CEN;
  logic              RAM_WEN;
  logic [AW-1:0]     RAM_ADD;
  logic [DW-1:0]     RAM_DIN;
  logic [DW-1:0]     RAM_DOUT = '0;

  eeg_wram_arb #(.REQ_NUM(RN), .ADD_AW(AW), .DAT_DW(DW), .WR_MAX(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .ETOW_DAT_VLD(ETOW_DAT_VLD), .ETOW_DAT_RDY(ETOW_DAT_RDY),
    .ETOW_DAT_ADD(ETOW_DAT_ADD), .ETOW_DAT_DAT(ETOW_DAT_DAT),
    .PTOW_ADD_VLD(PTOW_ADD_VLD), .PTOW_ADD_RDY(PTOW_ADD_RDY),
    .PTOW_ADD_ADD(PTOW_ADD_ADD),
    .PTOW_DAT_VLD(PTOW_DAT_VLD), .PTOW_DAT_RDY(PTOW_DAT_RDY),
    .PTOW_DAT_DAT(PTOW_DAT_DAT),
    .RAM_CEN(RAM_CEN), .RAM_WEN(RAM_WEN), .RAM_ADD(RAM_ADD),
    .RAM_DIN(RAM_DIN), .RAM_DOUT(RAM_DOUT)
  );

  always #5 clk = ~clk;

  // SRAM macro model and the bench's own reference image of its contents
  logic [DW-1:0] mem     [512];
  logic [DW-1:0] ref_mem [512];
  always @(posedge clk) begin
    if (RAM_CEN) begin
      if (RAM_WEN) mem[RAM_ADD] <= RAM_DIN;
      else         RAM_DOUT     <= mem[RAM_ADD];
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Scoreboard: expected read data queued at address handshake, compared at data handshake
  logic [DW-1:0] sbq [RN][$];
  always @(negedge clk) begin
    #4;
    if (!rst_n) begin
      for (int i = 0; i < RN; i++) sbq[i].delete();
    end else begin
      for (int i = 0; i < RN; i++) begin
        if (PTOW_DAT_VLD[i] && PTOW_DAT_RDY[i]) begin
          if (sbq[i].size() == 0) chk($sformatf("sb_unexpected_lane%0d", i), PTOW_DAT_VLD[i], 1'b0);
          else chk($sformatf("sb_data_lane%0d", i), PTOW_DAT_DAT[i*DW +: DW], sbq[i].pop_front());
        end
        if (PTOW_ADD_VLD[i] && PTOW_ADD_RDY[i])
          sbq[i].push_back(ref_mem[PTOW_ADD_ADD[i*AW +: AW]]);
      end
      if (ETOW_DAT_VLD && ETOW_DAT_RDY) ref_mem[ETOW_DAT_ADD] = ETOW_DAT_DAT;
    end
  end

  typedef struct {
    logic          ev;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic [RN-1:0] pv;
    logic [AW-1:0] pa;
    logic          x_erdy;
    logic [RN-1:0] x_prdy;
    logic          x_cen;
    logic          x_wen;
    logic [AW-1:0] x_add;
  } vec_t;

  vec_t vt [18];

  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    ETOW_DAT_VLD = v.ev;
    ETOW_DAT_ADD = v.ea;
    ETOW_DAT_DAT = v.ed;
    PTOW_ADD_VLD = v.pv;
    for (int i = 0; i < RN; i++) PTOW_ADD_ADD[i*AW +: AW] = v.pa + AW'(i);
    #4;
    chk($sformatf("v%0d_erdy", idx), ETOW_DAT_RDY, v.x_erdy);
    chk($sformatf("v%0d_prdy", idx), PTOW_ADD_RDY, v.x_prdy);
    chk($sformatf("v%0d_cen", idx), RAM_CEN, v.x_cen);
    chk($sformatf("v%0d_wen", idx), RAM_WEN, v.x_wen);
    chk($sformatf("v%0d_add", idx), RAM_ADD, v.x_add);
    if (v.x_wen) chk($sformatf("v%0d_din", idx), RAM_DIN, v.ed);
  endtask

  task automatic idle_inputs();
    ETOW_DAT_VLD = 1'b0;
    PTOW_ADD_VLD = '0;
    PTOW_DAT_RDY = '1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic idle_cycles(input int n);
    @(negedge clk);
    idle_inputs();
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic got;
    for (int i = 0; i < 512; i++) begin
      mem[i]     = 32'hA5A5_0000 ^ (i * 32'h0101_0101);
      ref_mem[i] = 32'hA5A5_0000 ^ (i * 32'h0101_0101);
    end
    mem[5]     = 32'hDEAD_BEEF;
    ref_mem[5] = 32'hDEAD_BEEF;

    // Round-robin: all four lanes valid from reset, rr_ptr starts at 0
    for (int k = 0; k < 8; k++)
      vt[k] = '{ev: 1'b0, ea: '0, ed: '0, pv: 4'hF, pa: 9'h040, x_erdy: 1'b0,
                x_prdy: 4'(1 << (k % 4)), x_cen: 1'b1, x_wen: 1'b0, x_add: 9'h040 + 9'(k % 4)};
    // Starvation cap: 8 writes, one read for lane 1 (addr 0x31), writes resume
    for (int k = 0; k < 10; k++)
      vt[8+k] = '{ev: 1'b1, ea: 9'h100 + 9'(k), ed: 32'hC0DE_0000 + 32'(k), pv: 4'b0010, pa: 9'h030,
                  x_erdy: (k != 8), x_prdy: (k == 8) ? 4'b0010 : 4'b0000, x_cen: 1'b1,
                  x_wen: (k != 8), x_add: (k == 8) ? 9'h031 : 9'h100 + 9'(k)};

    #1;
    chk("rst_cen", RAM_CEN, 1'b0);
    chk("rst_wen", RAM_WEN, 1'b0);
    chk("rst_dvld", PTOW_DAT_VLD, 4'h0);
    chk("rst_add", RAM_ADD, 9'h000);
    chk("rst_din", RAM_DIN, 32'h0);
    do_reset();

    for (int k = 0; k < 8; k++) apply(vt[k], k);
    idle_cycles(6);
    do_reset();
    for (int k = 8; k < 18; k++) apply(vt[k], k);
    idle_cycles(6);

    // Single read on lane 2
    do_reset();
    @(negedge clk);
    PTOW_ADD_VLD = 4'b0100;
    PTOW_ADD_ADD[2*AW +: AW] = 9'h005;
    #4;
    chk("t1_rdy", PTOW_ADD_RDY, 4'b0100);
    chk("t1_cen0", RAM_CEN, 1'b1);
    @(negedge clk);
    PTOW_ADD_VLD = '0;
    #4;
    chk("t1_cen1", RAM_CEN, 1'b0);
    chk("t1_dvld1", PTOW_DAT_VLD, 4'b0000);
    @(negedge clk);
    #4;
    chk("t1_dvld2", PTOW_DAT_VLD, 4'b0100);
    chk("t1_dat2", PTOW_DAT_DAT[2*DW +: DW], 32'hDEAD_BEEF);
    chk("t1_cen2", RAM_CEN, 1'b0);
    chk("t1_addhold", RAM_ADD, 9'h005);
    idle_cycles(3);

    // Backpressure on lane 0
    do_reset();
    @(negedge clk);
    PTOW_DAT_RDY = 4'b1110;
    PTOW_ADD_VLD = 4'b0001;
    PTOW_ADD_ADD[0 +: AW] = 9'h010;
    #4;
    chk("t3_rdy_a", PTOW_ADD_RDY[0], 1'b1);
    @(negedge clk);
    PTOW_ADD_ADD[0 +: AW] = 9'h011;
    #4;
    chk("t3_rdy_b", PTOW_ADD_RDY[0], 1'b1);
    @(negedge clk);
    PTOW_ADD_ADD[0 +: AW] = 9'h012;
    #4;
    chk("t3_stall0", PTOW_ADD_RDY[0], 1'b0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      #4;
      chk($sformatf("t3_stall%0d", k + 1), PTOW_ADD_RDY[0], 1'b0);
    end
    @(negedge clk);
    PTOW_DAT_RDY = 4'b1111;
    #4;
    chk("t3_stall_full", PTOW_ADD_RDY[0], 1'b0);
    got = 1'b0;
    for (int k = 0; k < 8 && !got; k++) begin
      @(negedge clk);
      #4;
      got = PTOW_ADD_RDY[0];
    end
    chk("t3_accept_third", got, 1'b1);
    idle_cycles(6);
    chk("t3_drained", sbq[0].size(), 0);

    // Read after write on lane 3
    do_reset();
    @(negedge clk);
    ETOW_DAT_VLD = 1'b1;
    ETOW_DAT_ADD = 9'h020;
    ETOW_DAT_DAT = 32'h0000_00AA;
    #4;
    chk("t5_erdy", ETOW_DAT_RDY, 1'b1);
    @(negedge clk);
    ETOW_DAT_VLD = 1'b0;
    PTOW_ADD_VLD = 4'b1000;
    PTOW_ADD_ADD[3*AW +: AW] = 9'h020;
    #4;
    chk("t5_prdy", PTOW_ADD_RDY, 4'b1000);
    chk("t5_din_hold", RAM_DIN, 32'h0000_00AA);
    @(negedge clk);
    PTOW_ADD_VLD = '0;
    got = 1'b0;
    for (int k = 0; k < 5 && !got; k++) begin
      #4;
      if (PTOW_DAT_VLD[3]) begin
        got = 1'b1;
        chk("t5_data", PTOW_DAT_DAT[3*DW +: DW], 32'h0000_00AA);
      end
      else @(negedge clk);
    end
    chk("t5_seen", got, 1'b1);
    idle_cycles(3);

    // Reset in the cycle after a lane 1 grant
    do_reset();
    @(negedge clk);
    PTOW_ADD_VLD = 4'b0010;
    PTOW_ADD_ADD[1*AW +: AW] = 9'h033;
    #4;
    chk("t6_grant", PTOW_ADD_RDY, 4'b0010);
    @(negedge clk);
    PTOW_ADD_VLD = '0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_cen", RAM_CEN, 1'b0);
    chk("t6_wen", RAM_WEN, 1'b0);
    chk("t6_add", RAM_ADD, 9'h000);
    chk("t6_dvld", PTOW_DAT_VLD, 4'h0);
    chk("t6_dat1", PTOW_DAT_DAT[1*DW +: DW], 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      #4;
      chk($sformatf("t6_novld%0d", k), PTOW_DAT_VLD, 4'h0);
    end

    for (int i = 0; i < RN; i++) chk($sformatf("sb_empty_lane%0d", i), sbq[i].size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
